fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the add/sub datapath.
- Holds the PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned words in a small FIFO and presents them downstream with valid/ready. Downstream uses instr_valid && instr_ready as its write-back enable.
- Supports a PC redirect that flushes buffered and in-flight instructions.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch FSM state type
//
// Purpose: common widths and the fetch-stage state encoding used by
//          fetch_unit and fetch_fifo.
// Ports:   none (package).

package cpu_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small instruction buffer between memory and decode
//
// Purpose: DEPTH-entry FIFO of instruction words. Flush wins over push/pop.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   push        write push_data at the tail
//   push_data   instruction word to store
//   pop         retire the head entry
//   flush       discard every entry
//   count       number of valid entries (0..DEPTH)
//   head        head entry, 0 when empty
//   empty       no valid entries

module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [XLEN-1:0]              push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [XLEN-1:0]              head,
   output logic                         empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   assign empty = (count == '0);
   assign head  = empty ? '0 : mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap modulo DEPTH on overflow.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, memory handshake and buffer
//
// Purpose: holds the PC, issues word requests over req/ack, buffers returned
//          words and presents them downstream with valid/ready. A redirect
//          flushes buffered words and kills any in-flight request.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   fetch_en          allow new memory requests
//   imem_req/addr     registered request and word-aligned address
//   imem_ack/rdata    completion and data, sampled when imem_req && imem_ack
//   instr/instr_valid FIFO head (0 when empty) and non-empty flag
//   instr_ready       downstream accepts the head
//   redirect_valid/pc flush and restart fetch at redirect_pc & ~3

module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fetch_en,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instr,
   output logic            instr_valid,
   input  logic            instr_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] head;
   logic            empty;
   logic            push;
   logic            pop;
   logic            idle_room;
   logic            room_after;
   logic [CW:0]     count_after;

   // Only a live (non-redirected) completion in REQ writes the buffer.
   assign push = (state == REQ) && imem_ack && !redirect_valid;
   assign pop  = !empty && instr_ready && !redirect_valid;

   assign instr_valid = !empty;
   assign instr       = head;

   // In IDLE nothing is outstanding, so occupancy is just the FIFO count.
   assign idle_room = ({1'b0, count} < (CW+1)'(FIFO_DEPTH));

   // After an ack the finished request is no longer outstanding; the next
   // back-to-back request reserves one slot, so it needs count_after < DEPTH.
   assign count_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
   assign room_after  = (count_after < (CW+1)'(FIFO_DEPTH));

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (imem_rdata),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (count),
      .head      (head),
      .empty     (empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         if (redirect_valid) begin
            pc <= redirect_pc & ~XLEN'(INSTR_BYTES - 1);
         end else if (push) begin
            pc <= pc + XLEN'(INSTR_BYTES);
         end

         case (state)
            IDLE: begin
               if (fetch_en && idle_room && !redirect_valid) begin
                  state     <= REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  if (!redirect_valid && fetch_en && room_after) begin
                     imem_addr <= pc + XLEN'(INSTR_BYTES);
                  end else begin
                     state    <= IDLE;
                     imem_req <= 1'b0;
                  end
               end else if (redirect_valid) begin
                  // Request cannot be withdrawn; wait for it and drop the data.
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (imem_ack) begin
                  state    <= IDLE;
                  imem_req <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic        fetch_en2;
   logic        req2;
   logic [31:0] addr2;
   logic        ack2;
   logic [31:0] rdata2;
   logic [31:0] instr2;
   logic        valid2;
   logic        ready2;

   int          mem_lat;
   int          wcnt;
   logic        dead_mode;

   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   fetch_unit #(
      .RESET_PC   (32'hFFFF_FFFC),
      .FIFO_DEPTH (2)
   ) dut_wrap (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en2),
      .imem_req       (req2),
      .imem_addr      (addr2),
      .imem_ack       (ack2),
      .imem_rdata     (rdata2),
      .instr          (instr2),
      .instr_valid    (valid2),
      .instr_ready    (ready2),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0)
   );

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory responder: ack after mem_lat waiting cycles of a held request.
   always @(negedge clk) begin
      if (imem_req && rst_n) begin
         if (wcnt >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = dead_mode ? 32'h0000_DEAD : word_of(imem_addr);
            wcnt       = 0;
         end else begin
            imem_ack = 1'b0;
            wcnt     = wcnt + 1;
         end
      end else begin
         imem_ack = 1'b0;
         wcnt     = 0;
      end
   end

   task automatic do_reset();
      rst_n          = 1'b0;
      fetch_en       = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      mem_lat        = 0;
      dead_mode      = 1'b0;
      fetch_en2      = 1'b0;
      ack2           = 1'b0;
      rdata2         = 32'h0;
      ready2         = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL reset_req: got %b expected 0", imem_req);
      end
      checks++;
      if (imem_addr !== 32'h0) begin
         errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr);
      end
      checks++;
      if ({instr_valid, instr} !== 33'h0) begin
         errors++; $display("FAIL reset_instr: got valid=%b instr=%h expected 0/0", instr_valid, instr);
      end
      checks++;
      if ({req2, addr2} !== {1'b0, 32'hFFFF_FFFC}) begin
         errors++; $display("FAIL reset_wrap_addr: got req=%b addr=%h expected 0/fffffffc", req2, addr2);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      logic [31:0] ea;
      do_reset();
      fetch_en    = 1'b1;
      instr_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i <= 4) begin
            ea = 32'(4 * (i - 1));
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, ea}) begin
               errors++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h expected 1/%h", i, imem_req, imem_addr, ea);
            end
         end
         if (i == 1) begin
            checks++;
            if (instr_valid !== 1'b0) begin
               errors++; $display("FAIL stream_first_valid: got %b expected 0", instr_valid);
            end
         end else begin
            ea = word_of(32'(4 * (i - 2)));
            checks++;
            if ({instr_valid, instr} !== {1'b1, ea}) begin
               errors++; $display("FAIL stream_instr[%0d]: got valid=%b instr=%h expected 1/%h", i, instr_valid, instr, ea);
            end
         end
      end
      fetch_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_slow_mem();
      logic [31:0] ea;
      logic        ev;
      do_reset();
      mem_lat     = 3;
      fetch_en    = 1'b1;
      instr_ready = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         ea = 32'(4 * ((c - 1) / 4));
         checks++;
         if ({imem_req, imem_addr} !== {1'b1, ea}) begin
            errors++; $display("FAIL slow_addr[%0d]: got req=%b addr=%h expected 1/%h", c, imem_req, imem_addr, ea);
         end
         ev = (c >= 5) && (((c - 1) % 4) == 0);
         checks++;
         if (instr_valid !== ev) begin
            errors++; $display("FAIL slow_valid[%0d]: got %b expected %b", c, instr_valid, ev);
         end
         if (ev) begin
            ea = word_of(32'(4 * ((c - 5) / 4)));
            checks++;
            if (instr !== ea) begin
               errors++; $display("FAIL slow_instr[%0d]: got %h expected %h", c, instr, ea);
            end
         end
      end
      fetch_en = 1'b0;
      repeat (6) @(negedge clk);
      mem_lat = 0;
   endtask

   task automatic test_stall();
      do_reset();
      fetch_en    = 1'b1;
      instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 3; i <= 6; i++) begin
         @(negedge clk);
         checks++;
         if (imem_req !== 1'b0) begin
            errors++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req);
         end
         checks++;
         if ({instr_valid, instr} !== {1'b1, 32'hC0DE_0000}) begin
            errors++; $display("FAIL stall_head[%0d]: got valid=%b instr=%h expected 1/c0de0000", i, instr_valid, instr);
         end
      end
      instr_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({imem_req, instr_valid, instr} !== {2'b01, 32'hC0DE_0004}) begin
         errors++; $display("FAIL stall_drain1: got req=%b valid=%b instr=%h expected 0/1/c0de0004", imem_req, instr_valid, instr);
      end
      @(negedge clk);
      checks++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h8, 1'b0}) begin
         errors++; $display("FAIL stall_resume: got req=%b addr=%h valid=%b expected 1/00000008/0", imem_req, imem_addr, instr_valid);
      end
      @(negedge clk);
      checks++;
      if ({instr_valid, instr} !== {1'b1, 32'hC0DE_0008}) begin
         errors++; $display("FAIL stall_next: got valid=%b instr=%h expected 1/c0de0008", instr_valid, instr);
      end
      fetch_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_redirect_wait();
      do_reset();
      mem_lat     = 10;
      dead_mode   = 1'b1;
      fetch_en    = 1'b1;
      instr_ready = 1'b1;
      repeat (2) @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      for (int i = 3; i <= 11; i++) begin
         @(negedge clk);
         redirect_valid = 1'b0;
         checks++;
         if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++; $display("FAIL drain_hold[%0d]: got req=%b addr=%h valid=%b expected 1/00000000/0", i, imem_req, imem_addr, instr_valid);
         end
      end
      @(negedge clk);
      checks++;
      if ({imem_req, instr_valid, instr} !== 34'h0) begin
         errors++; $display("FAIL drain_done: got req=%b valid=%b instr=%h expected 0/0/0", imem_req, instr_valid, instr);
      end
      dead_mode = 1'b0;
      mem_lat   = 0;
      @(negedge clk);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
         errors++; $display("FAIL redirect_addr: got req=%b addr=%h expected 1/00000100", imem_req, imem_addr);
      end
      @(negedge clk);
      checks++;
      if ({instr_valid, instr} !== {1'b1, 32'hC0DE_0100}) begin
         errors++; $display("FAIL redirect_instr: got valid=%b instr=%h expected 1/c0de0100", instr_valid, instr);
      end
      fetch_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_redirect_ack();
      do_reset();
      fetch_en    = 1'b1;
      instr_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({instr_valid, instr, imem_req, imem_addr} !== {1'b1, 32'hC0DE_0000, 1'b1, 32'h4}) begin
         errors++; $display("FAIL rack_pre: got valid=%b instr=%h req=%b addr=%h expected 1/c0de0000/1/00000004", instr_valid, instr, imem_req, imem_addr);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0203;
      @(negedge clk);
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      checks++;
      if ({instr_valid, instr, imem_req} !== 34'h0) begin
         errors++; $display("FAIL rack_flush: got valid=%b instr=%h req=%b expected 0/0/0", instr_valid, instr, imem_req);
      end
      @(negedge clk);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
         errors++; $display("FAIL rack_addr: got req=%b addr=%h expected 1/00000200", imem_req, imem_addr);
      end
      @(negedge clk);
      checks++;
      if ({instr_valid, instr} !== {1'b1, 32'hC0DE_0200}) begin
         errors++; $display("FAIL rack_instr: got valid=%b instr=%h expected 1/c0de0200", instr_valid, instr);
      end
      fetch_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      do_reset();
      fetch_en    = 1'b1;
      instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({imem_req, instr_valid} !== 2'b11) begin
         errors++; $display("FAIL rmid_pre: got req=%b valid=%b expected 1/1", imem_req, instr_valid);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({imem_req, imem_addr, instr_valid, instr} !== 66'h0) begin
         errors++; $display("FAIL rmid_state: got req=%b addr=%h valid=%b instr=%h expected all 0", imem_req, imem_addr, instr_valid, instr);
      end
      rst_n    = 1'b1;
      fetch_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_wrap();
      logic [31:0] exp_addr [3];
      exp_addr[0] = 32'hFFFF_FFFC;
      exp_addr[1] = 32'h0000_0000;
      exp_addr[2] = 32'h0000_0004;
      do_reset();
      fetch_en2 = 1'b1;
      ready2    = 1'b1;
      ack2      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rdata2 = word_of(addr2);
         checks++;
         if ({req2, addr2} !== {1'b1, exp_addr[i]}) begin
            errors++; $display("FAIL wrap_addr[%0d]: got req=%b addr=%h expected 1/%h", i, req2, addr2, exp_addr[i]);
         end
         if (i > 0) begin
            checks++;
            if ({valid2, instr2} !== {1'b1, word_of(exp_addr[i-1])}) begin
               errors++; $display("FAIL wrap_instr[%0d]: got valid=%b instr=%h expected 1/%h", i, valid2, instr2, word_of(exp_addr[i-1]));
            end
         end
      end
      fetch_en2 = 1'b0;
      repeat (3) @(negedge clk);
      ack2 = 1'b0;
   endtask

   initial begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      wcnt       = 0;
      test_reset();
      test_stream();
      test_slow_mem();
      test_stall();
      test_redirect_wait();
      test_redirect_ack();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
